// File: rtl/lives_ctrl_pkg.sv
// Shared definitions for the lives manager: state encoding and default tuning
// values used by the overlay and the game logic.
package lives_ctrl_pkg;

    typedef enum logic [1:0] {
        PLAY   = 2'd0,
        INVULN = 2'd1,
        DEAD   = 2'd2
    } lives_state_t;

    localparam int unsigned DEF_MAX_LIVES     = 2;
    localparam int unsigned DEF_INVULN_FRAMES = 120;
    localparam int unsigned DEF_BLINK_SHIFT   = 3;
    localparam int unsigned FRAME_CNT_W       = 8;
    localparam int unsigned LIVES_W           = 2;

endpackage

// File: rtl/lives_ctrl_frame_timer.sv
// 8-bit frame counter with clear, frame_tick enable and terminal-count compare;
// wraps to zero on an enabled tick at terminal count.
module frame_timer
    import lives_ctrl_pkg::*;
#(
    parameter int unsigned TERMINAL = DEF_INVULN_FRAMES
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clr,
    input  logic                   en,
    output logic [FRAME_CNT_W-1:0] cnt,
    output logic [FRAME_CNT_W-1:0] cnt_nxt_c,
    output logic                   tc_c
);

    assign tc_c = (cnt == FRAME_CNT_W'(TERMINAL - 1));

    always_comb begin
        cnt_nxt_c = cnt;
        if (clr) begin
            cnt_nxt_c = '0;
        end else if (en) begin
            cnt_nxt_c = tc_c ? '0 : cnt + FRAME_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt_c;
        end
    end

endmodule

// File: rtl/lives_ctrl.sv
// Lives manager: damage with frame-counted invulnerability, heart blink, game over.
// Optional bonus life is built only when LIVES_BONUS_EN is defined.
module lives_ctrl
    import lives_ctrl_pkg::*;
#(
    parameter int unsigned MAX_LIVES     = DEF_MAX_LIVES,
    parameter int unsigned INVULN_FRAMES = DEF_INVULN_FRAMES,
    parameter int unsigned BLINK_SHIFT   = DEF_BLINK_SHIFT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               hit,
    input  logic               bonus,
    input  logic               restart,
    output logic [LIVES_W-1:0] lives,
    output logic               heart_blank,
    output logic               invuln,
    output logic               game_over,
    output logic               life_lost
);

    localparam logic [LIVES_W-1:0] LIVES_FULL = LIVES_W'(MAX_LIVES);

    lives_state_t             state, state_nxt;
    logic [LIVES_W-1:0]       lives_nxt;
    logic                     life_lost_nxt;
    logic                     tmr_clr, tmr_en, tmr_tc;
    logic [FRAME_CNT_W-1:0]   frame_cnt, frame_cnt_nxt;
    logic                     bonus_ok;

`ifdef LIVES_BONUS_EN
    assign bonus_ok = bonus && !hit && (lives < LIVES_FULL);
`else
    logic unused_bonus;
    assign unused_bonus = bonus;
    assign bonus_ok     = 1'b0;
`endif

    frame_timer #(.TERMINAL(INVULN_FRAMES)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clr       (tmr_clr),
        .en        (tmr_en),
        .cnt       (frame_cnt),
        .cnt_nxt_c (frame_cnt_nxt),
        .tc_c      (tmr_tc)
    );

    // Next-state, lives and timer control; restart overrides everything below it.
    always_comb begin
        state_nxt     = state;
        lives_nxt     = lives;
        life_lost_nxt = 1'b0;
        tmr_clr       = 1'b0;
        tmr_en        = 1'b0;
        if (restart) begin
            state_nxt = PLAY;
            lives_nxt = LIVES_FULL;
            tmr_clr   = 1'b1;
        end else begin
            case (state)
                PLAY: begin
                    if (hit) begin
                        life_lost_nxt = 1'b1;
                        tmr_clr       = 1'b1;
                        if (lives > LIVES_W'(1)) begin
                            lives_nxt = lives - LIVES_W'(1);
                            state_nxt = INVULN;
                        end else begin
                            lives_nxt = '0;
                            state_nxt = DEAD;
                        end
                    end else if (bonus_ok) begin
                        lives_nxt = lives + LIVES_W'(1);
                    end
                end
                INVULN: begin
                    tmr_en = frame_tick;
                    if (frame_tick && tmr_tc) begin
                        state_nxt = PLAY;
                    end
                    if (bonus_ok) begin
                        lives_nxt = lives + LIVES_W'(1);
                    end
                end
                DEAD: begin
                    state_nxt = DEAD;
                end
                default: begin
                    state_nxt = PLAY;
                    tmr_clr   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= PLAY;
            lives       <= LIVES_FULL;
            life_lost   <= 1'b0;
            invuln      <= 1'b0;
            game_over   <= 1'b0;
            heart_blank <= 1'b0;
        end else begin
            state       <= state_nxt;
            lives       <= lives_nxt;
            life_lost   <= life_lost_nxt;
            invuln      <= (state_nxt == INVULN);
            game_over   <= (state_nxt == DEAD);
            heart_blank <= (state_nxt == INVULN) && frame_cnt_nxt[BLINK_SHIFT];
        end
    end

endmodule

// File: tb/tb_lives_ctrl.sv
// Self-checking bench for lives_ctrl: directed scenarios then random pulses,
// all compared against a behavioural game-rules model.
module tb_lives_ctrl;

    localparam int MAXL   = 2;
    localparam int FRAMES = 120;
    localparam int BSHIFT = 3;
`ifdef LIVES_BONUS_EN
    localparam bit BONUS_ON = 1'b1;
`else
    localparam bit BONUS_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       frame_tick = 1'b0;
    logic       hit = 1'b0;
    logic       bonus = 1'b0;
    logic       restart = 1'b0;
    logic [1:0] lives;
    logic       heart_blank, invuln, game_over, life_lost;

    int errors = 0;
    int checks = 0;

    // Model of the game rules
    int m_lives = MAXL;
    bit m_inv = 0;
    bit m_dead = 0;
    int m_frames = 0;
    bit m_lost = 0;

    lives_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .hit         (hit),
        .bonus       (bonus),
        .restart     (restart),
        .lives       (lives),
        .heart_blank (heart_blank),
        .invuln      (invuln),
        .game_over   (game_over),
        .life_lost   (life_lost)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update(input bit rs, input bit r, input bit h, input bit b, input bit t);
        m_lost = 0;
        if (rs || r) begin
            m_lives = MAXL; m_inv = 0; m_dead = 0; m_frames = 0;
        end else if (m_dead) begin
            // only restart leaves the game-over screen
        end else if (m_inv) begin
            if (t) begin
                m_frames++;
                if (m_frames == FRAMES) begin
                    m_inv = 0; m_frames = 0;
                end
            end
            if (BONUS_ON && b && !h && m_lives < MAXL) m_lives++;
        end else begin
            if (h) begin
                m_lost = 1;
                if (m_lives > 1) begin
                    m_lives--; m_inv = 1; m_frames = 0;
                end else begin
                    m_lives = 0; m_dead = 1;
                end
            end else if (BONUS_ON && b && m_lives < MAXL) begin
                m_lives++;
            end
        end
    endtask

    task automatic step(input bit rs, input bit r, input bit h, input bit b, input bit t);
        @(negedge clk);
        reset = rs; restart = r; hit = h; bonus = b; frame_tick = t;
        @(posedge clk);
        model_update(rs, r, h, b, t);
        #1;
        check("lives", int'(lives), m_lives);
        check("invuln", int'(invuln), int'(m_inv));
        check("game_over", int'(game_over), int'(m_dead));
        check("life_lost", int'(life_lost), int'(m_lost));
        check("heart_blank", int'(heart_blank), (m_inv && ((m_frames / (1 << BSHIFT)) % 2 == 1)) ? 1 : 0);
    endtask

    initial begin
        // Reset and idle
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0);
        check("idle_lives", int'(lives), 2);

        // Hit, then an ignored hit five frames into the window
        step(0, 0, 1, 0, 0);
        check("hit_lives", int'(lives), 1);
        check("hit_lost", int'(life_lost), 1);
        step(0, 0, 0, 0, 0);
        check("lost_pulse_end", int'(life_lost), 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0);
        check("inv_hit_ignored", int'(lives), 1);
        for (int i = 5; i < FRAMES - 1; i++) begin
            step(0, 0, 0, 0, 1);
            if (i == 7) check("blink_first_high", int'(heart_blank), 1);
        end
        check("still_invuln", int'(invuln), 1);
        step(0, 0, 0, 0, 1);
        check("window_over", int'(invuln), 0);

        // Last life, then dead ignores hit and bonus
        step(0, 0, 1, 0, 0);
        check("dead_flag", int'(game_over), 1);
        step(0, 0, 1, 1, 1);
        step(0, 0, 0, 1, 0);
        check("dead_lives", int'(lives), 0);
        step(0, 1, 0, 0, 0);
        check("restart_lives", int'(lives), 2);

        // Bonus behaviour
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        check("bonus_at_1", int'(lives), BONUS_ON ? 2 : 1);
        step(0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 1, 0);
        check("hit_beats_bonus", int'(lives), 1);

        // Restart + tick + hit during the window
        step(0, 0, 0, 0, 1);
        step(0, 1, 1, 0, 1);
        check("restart_wins", int'(lives), 2);
        check("restart_inv", int'(invuln), 0);
        // frame_cnt must be 0: a new hit then 8 ticks raises the blink exactly then
        step(0, 0, 1, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1);
        check("restart_cnt_zero", int'(heart_blank), 1);

        // Random pulses
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 499) == 0),
                 ($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 2) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lives_ctrl.md
# lives_ctrl

Sequential lives manager for the game screen. Holds the player's remaining-lives count and drives the 2-bit `lives` input of the heart overlay. Applies damage with a frame-counted invulnerability window and produces a blink-blank signal that gates heart display during that window. Flags game over and accepts an optional bonus life.

## Interface
- `MAX_LIVES`, 2: lives after reset/restart and saturation ceiling (1..3).
- `INVULN_FRAMES`, 120: frames of invulnerability after a hit (1..255).
- `BLINK_SHIFT`, 3: blink half-period is 2^BLINK_SHIFT frames (0..6).
- `clk`  in  1  system/pixel clock.
- `reset`  in  1  synchronous, active-high reset.
- `frame_tick`  in  1  one-cycle pulse per video frame (start of vblank).
- `hit`  in  1  one-cycle pulse: player took damage.
- `bonus`  in  1  one-cycle pulse: extra life (effective only with the bonus macro).
- `restart`  in  1  one-cycle pulse: start a new game.
- `lives`  out  2  remaining lives, to the heart overlay.
- `heart_blank`  out  1  1 = suppress heart pixels this frame (blink phase).
- `invuln`  out  1  1 while invulnerable.
- `game_over`  out  1  1 while no lives remain.
- `life_lost`  out  1  one-cycle pulse when a life is deducted.

## Operation
- States: PLAY, INVULN, DEAD. `frame_cnt` is an 8-bit counter.
- Priority each cycle: `reset` > `restart` > `hit` > `bonus`.
- `restart` in any state: lives=MAX_LIVES, PLAY, frame_cnt=0, outputs cleared.
- PLAY + `hit`, lives>1: lives-1, `life_lost`=1, frame_cnt=0, go to INVULN.
- PLAY + `hit`, lives==1: lives=0, `life_lost`=1, go to DEAD.
- INVULN: `hit` is ignored. On each `frame_tick` frame_cnt+1. A tick with frame_cnt==INVULN_FRAMES-1 returns to PLAY and clears frame_cnt.
- DEAD: `game_over`=1. `hit` and `bonus` are ignored. Only `restart`/`reset` exit.
- `bonus` (PLAY or INVULN): lives+1, saturating at MAX_LIVES. Does not change state or frame_cnt. If `hit` is active in the same cycle, `bonus` is dropped.
- `heart_blank` = INVULN && frame_cnt[BLINK_SHIFT]. It is 0 in PLAY and DEAD.
- `invuln` = (state==INVULN). `game_over` = (state==DEAD).
- Lives arithmetic is 2-bit unsigned. No underflow below 0 and no overflow above MAX_LIVES.

## Timing
- All outputs are registered. An input pulse sampled at edge N updates outputs visible after edge N.
- Latency is 1 cycle from `hit`/`bonus`/`restart` to `lives` and state outputs.
- `life_lost` is high for exactly the one cycle after the accepted hit.
- `frame_tick` coincident with `hit` in PLAY: the hit is taken, and frame_cnt starts at 0. The tick is not counted.
- `frame_tick` coincident with `restart`: the restart wins, and frame_cnt=0.
- Reset values:
  - `lives`=MAX_LIVES
  - state PLAY
  - `heart_blank`=0
  - `invuln`=0
  - `game_over`=0
  - `life_lost`=0
  - frame_cnt=0
- Reset or restart during INVULN aborts the window immediately.

## Configuration
- `LIVES_BONUS_EN` defined: `bonus` input is honoured as described above.
- `LIVES_BONUS_EN` undefined: `bonus` is ignored, the saturating-increment logic is not built, and lives only decrease or restore on restart/reset.

## Structure
- The shared package holds:
  - the state encoding localparams (PLAY=2'd0, INVULN=2'd1, DEAD=2'd2);
  - the default MAX_LIVES, INVULN_FRAMES and BLINK_SHIFT values, shared with the overlay and the game logic.
- One sub-module: `frame_timer`. It is an 8-bit frame counter with clear, a `frame_tick` enable and a terminal-count compare output, used for the invulnerability window and the blink phase.

## Test plan
- Reset, then idle 10 cycles -> lives=2, invuln=0, game_over=0, heart_blank=0.
- Hit in PLAY -> next cycle lives=1, life_lost=1 for 1 cycle, invuln=1. A second hit 5 frames later -> ignored, lives stays 1.
- After a hit, issue 120 frame_ticks -> invuln falls right after the 120th tick. heart_blank toggles every 8 ticks (first high after tick 8).
- Hits with lives=1 after the window -> lives=0, game_over=1. Further hit/bonus -> no change. Then restart -> lives=2, PLAY.
- With LIVES_BONUS_EN: bonus at lives=1 -> lives=2. Bonus at lives=2 -> stays 2. Hit+bonus in the same cycle at lives=2 -> lives=1. Without the macro: bonus at lives=1 -> stays 1.
- Restart and frame_tick in the same cycle as a hit during INVULN -> restart wins: lives=2, invuln=0, frame_cnt=0.
